abstract_cmd_gen: RTL and testbench
===================================

# abstract_cmd_gen

Debug-module block that turns an Access Register abstract command into a short stream of 32-bit RISC-V instructions and hands them one at a time to the hart's debug instruction-injection port. Data moves through `dscratch0` (0x7B2), and `dscratch1` (0x7B3) holds a saved `x1` during CSR access. Every sequence ends with `ebreak`, or with a jump to the program buffer when postexec is enabled. It sits between the DMI-facing command registers and the core's fetch stage, and generates the same encodings the core's decoder accepts as valid SYSTEM/JALR instructions.

## Interface
- `PROGBUF_ADDR`, default 12'h300: program buffer address, used as the `jalr` immediate. Must lie in the sign-extended 12-bit range.
- `clk` in 1: clock.
- `rst_n` in 1: synchronous, active-low reset.
- `cmd_valid` in 1: command offered.
- `cmd_ready` out 1: high only in IDLE.
- `cmd_write` in 1: 1 writes the register from `dscratch0`; 0 reads the register into `dscratch0`.
- `cmd_transfer` in 1: perform the register access.
- `cmd_postexec` in 1: jump to the program buffer instead of `ebreak`.
- `cmd_regno` in 16: 0x0000–0x0FFF selects CSR `regno[11:0]`; 0x1000–0x101F selects GPR `regno[4:0]`; other values are unsupported.
- `inst` out 32: instruction word.
- `inst_valid` out 1: `inst` is valid.
- `inst_ready` in 1: core accepts `inst`.
- `core_exc` in 1: the core raised an exception on an injected instruction.
- `done` out 1: one-cycle pulse, sequence completed.
- `err_valid` out 1: one-cycle pulse; `cmderr` is valid.
- `cmderr` out 3: 2 = not supported, 3 = exception. Holds its value until the next `err_valid`.

## Operation
- Encodings:
  - CSRR(rd, c) = {c, 5'd0, 3'b010, rd, 7'h73}
  - CSRW(c, rs) = {c, rs, 3'b001, 5'd0, 7'h73}
  - EBREAK = 32'h00100073
  - JMP = {PROGBUF_ADDR, 5'd0, 3'b000, 5'd0, 7'h67}
- Terminator T = JMP if postexec is enabled, otherwise EBREAK.
- Sequences:
  - GPR read: CSRW(0x7B2, xN), T.
  - GPR write: CSRR(xN, 0x7B2), T.
  - CSR read: CSRW(0x7B3, x1), CSRR(x1, C), CSRW(0x7B2, x1), CSRR(x1, 0x7B3), T.
  - CSR write: CSRW(0x7B3, x1), CSRR(x1, 0x7B2), CSRW(C, x1), CSRR(x1, 0x7B3), T.
  - `cmd_transfer`=0: T only.
- States:
  - IDLE → EMIT on accept of a supported command.
  - IDLE → ERR on accept with `cmd_transfer`=1 and unsupported `regno`.
  - EMIT → DONE on handshake of the last instruction.
  - EMIT → ERR on `core_exc`.
  - DONE → IDLE and ERR → IDLE unconditionally.
- Command fields are latched on accept; later input changes do not affect the running sequence.
- A 3-bit step counter indexes the sequence. It advances on an `inst_valid`&&`inst_ready` handshake. Length is 1, 2 or 5.

## Timing
- Reset values: `inst_valid`=0, `inst`=0, `done`=0, `err_valid`=0, `cmderr`=0, state IDLE, `cmd_ready`=1.
- Latency:
  - Accept in cycle N → `inst_valid`=1 with the first instruction in N+1.
  - Each handshake → the next instruction in the following cycle, with no bubble.
- Handshake: `inst` is held stable while `inst_valid` && !`inst_ready`. `inst_valid` never drops without a handshake, except on `core_exc` or reset.
- Completion: last handshake in cycle M → `done`=1 in M+1 (DONE state). `cmd_ready` returns in M+2.
- Unsupported `regno`: accept in N → `err_valid`=1 and `cmderr`=2 in N+1. No instruction is emitted; `done` stays 0.
- `core_exc` in EMIT (including the cycle of a handshake): exception wins. In the next cycle:
  - `inst_valid`=0 and `err_valid`=1 with `cmderr`=3;
  - the remaining instructions are dropped and `done` stays 0.
- `core_exc` outside EMIT is ignored.
- Reset mid-sequence: the block returns to IDLE in the next cycle. No `done` or `err_valid` pulse is produced.

## Configuration
- `ABSCMD_POSTEXEC_EN` defined:
  - `cmd_postexec`=1 selects JMP as the terminator.
- `ABSCMD_POSTEXEC_EN` undefined:
  - `cmd_postexec`=1 with no other error raises `err_valid` with `cmderr`=2 one cycle after accept, and no instructions are emitted.
  - The JMP encoding is not synthesized, and `PROGBUF_ADDR` is unused.

## Test plan
- GPR read: write=0, transfer=1, regno=0x1005, `inst_ready`=1 → 0x7B229073, 0x00100073 on consecutive cycles; `done` one cycle later.
- CSR write: write=1, regno=0x0341, `inst_ready` toggling every cycle → 0x7B309073, 0x7B2020F3, 0x34109073, 0x7B3020F3, 0x00100073, with each word held while stalled.
- Unsupported: regno=0x2000, transfer=1 → no `inst_valid`; `err_valid`=1 with `cmderr`=2 in N+1; `cmd_ready` back in N+2.
- Exception: `core_exc` coincident with the 3rd handshake of a CSR read → `inst_valid`=0, `cmderr`=3, no `done`.
- Postexec (macro defined, PROGBUF_ADDR=0x300): transfer=0 → single 0x30000067. With the macro undefined, the same command gives `cmderr`=2.
- Reset: `rst_n` low during step 2 of a CSR write → next cycle all outputs 0 and `cmd_ready`=1; a new command then starts from step 0.

Source files
------------

// File: rtl/abstract_cmd_gen.sv
// rtl/abstract_cmd_gen.sv - Access Register abstract command to injected instruction stream
//
// Purpose: accepts one Access Register abstract command and emits its RISC-V
// instruction sequence one word at a time over a valid/ready injection port.
// Data moves through dscratch0 (0x7B2); dscratch1 (0x7B3) preserves x1 while a
// CSR is accessed. Every sequence ends with ebreak, or with a jalr into the
// program buffer when postexec is built in and requested.
//
// Optional feature macro: ABSCMD_POSTEXEC_EN
//   defined   - cmd_postexec=1 terminates the sequence with a jump to PROGBUF_ADDR
//   undefined - cmd_postexec=1 is rejected with cmderr=2
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_valid/ready     command handshake (ready only while idle)
//   cmd_write           1: register <= dscratch0, 0: dscratch0 <= register
//   cmd_transfer        perform the register access
//   cmd_postexec        run the program buffer afterwards
//   cmd_regno[15:0]     0x0000-0x0FFF CSR, 0x1000-0x101F GPR
//   inst[31:0]          instruction word, inst_valid/inst_ready handshake
//   core_exc            core raised an exception on an injected instruction
//   done                one-cycle completion pulse
//   err_valid, cmderr   one-cycle error pulse; cmderr (2 unsupported, 3 exception) holds
module abstract_cmd_gen #(
  parameter logic [11:0] PROGBUF_ADDR = 12'h300
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_transfer,
  input  logic        cmd_postexec,
  input  logic [15:0] cmd_regno,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        core_exc,
  output logic        done,
  output logic        err_valid,
  output logic [2:0]  cmderr
);

  localparam logic [11:0] DSCRATCH0 = 12'h7B2;
  localparam logic [11:0] DSCRATCH1 = 12'h7B3;
  localparam logic [4:0]  X1        = 5'd1;
  localparam logic [31:0] EBREAK    = 32'h00100073;

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE, S_ERR} state_t;

  state_t      state, state_nxt;
  logic [2:0]  step;
  logic        lat_write, lat_transfer, lat_is_csr;
  logic [11:0] lat_regno;
  logic        accept, handshake, last_step, cmd_unsup, postexec_bad;
  logic [2:0]  seq_len;
  logic [31:0] term_word, seq_word;

  function automatic logic [31:0] csrr(input logic [4:0] rd, input logic [11:0] c);
    return {c, 5'd0, 3'b010, rd, 7'h73};
  endfunction

  function automatic logic [31:0] csrw(input logic [11:0] c, input logic [4:0] rs);
    return {c, rs, 3'b001, 5'd0, 7'h73};
  endfunction

`ifdef ABSCMD_POSTEXEC_EN
  localparam logic [31:0] JMP = {PROGBUF_ADDR, 5'd0, 3'b000, 5'd0, 7'h67};
  logic lat_postexec;
  assign postexec_bad = 1'b0;
  assign term_word    = lat_postexec ? JMP : EBREAK;
`else
  assign postexec_bad = cmd_postexec;
  assign term_word    = EBREAK;
`endif

  assign accept    = cmd_valid && (state == S_IDLE);
  assign handshake = inst_valid && inst_ready;
  // regno is only checked when a transfer is requested
  assign cmd_unsup = (cmd_transfer && (cmd_regno[15:12] != 4'h0)
                      && (cmd_regno[15:5] != 11'h080)) || postexec_bad;
  assign seq_len   = !lat_transfer ? 3'd1 : (lat_is_csr ? 3'd5 : 3'd2);
  assign last_step = (step == seq_len - 3'd1);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; an exception outranks a simultaneous final handshake
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept) state_nxt = cmd_unsup ? S_ERR : S_EMIT;
      S_EMIT:  if (core_exc) state_nxt = S_ERR;
               else if (handshake && last_step) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      S_ERR:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Command latch, step counter and sticky error code
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step         <= 3'd0;
      lat_write    <= 1'b0;
      lat_transfer <= 1'b0;
      lat_is_csr   <= 1'b0;
      lat_regno    <= 12'd0;
      cmderr       <= 3'd0;
`ifdef ABSCMD_POSTEXEC_EN
      lat_postexec <= 1'b0;
`endif
    end else begin
      if (accept) begin
        step         <= 3'd0;
        lat_write    <= cmd_write;
        lat_transfer <= cmd_transfer;
        lat_is_csr   <= (cmd_regno[15:12] == 4'h0);
        lat_regno    <= cmd_regno[11:0];
`ifdef ABSCMD_POSTEXEC_EN
        lat_postexec <= cmd_postexec;
`endif
        if (cmd_unsup) cmderr <= 3'd2;
      end else if (state == S_EMIT) begin
        if (core_exc)       cmderr <= 3'd3;
        else if (handshake) step   <= step + 3'd1;
      end
    end
  end

  // Sequence table indexed by step
  always_comb begin
    seq_word = term_word;
    if (lat_transfer) begin
      if (!lat_is_csr) begin
        if (step == 3'd0)
          seq_word = lat_write ? csrr(lat_regno[4:0], DSCRATCH0)
                               : csrw(DSCRATCH0, lat_regno[4:0]);
      end else begin
        case (step)
          3'd0:    seq_word = csrw(DSCRATCH1, X1);
          3'd1:    seq_word = lat_write ? csrr(X1, DSCRATCH0) : csrr(X1, lat_regno);
          3'd2:    seq_word = lat_write ? csrw(lat_regno, X1) : csrw(DSCRATCH0, X1);
          3'd3:    seq_word = csrr(X1, DSCRATCH1);
          default: seq_word = term_word;
        endcase
      end
    end
  end

  // Outputs
  always_comb begin
    cmd_ready  = (state == S_IDLE);
    inst_valid = (state == S_EMIT);
    inst       = (state == S_EMIT) ? seq_word : 32'd0;
    done       = (state == S_DONE);
    err_valid  = (state == S_ERR);
  end

endmodule

// File: tb/tb_abstract_cmd_gen.sv
// tb/tb_abstract_cmd_gen.sv - self-checking bench for abstract_cmd_gen
module tb_abstract_cmd_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_transfer, cmd_postexec;
  logic [15:0] cmd_regno;
  logic [31:0] inst;
  logic        inst_valid, inst_ready, core_exc, done, err_valid;
  logic [2:0]  cmderr;

  int passed = 0;
  int total  = 0;

  logic [31:0] exp_q[$];
  logic        exp_err;

  abstract_cmd_gen #(.PROGBUF_ADDR(12'h300)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_transfer(cmd_transfer), .cmd_postexec(cmd_postexec), .cmd_regno(cmd_regno),
    .inst(inst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .core_exc(core_exc), .done(done), .err_valid(err_valid), .cmderr(cmderr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] m_csrr(input int rd, input int c);
    return (c << 20) | (2 << 12) | (rd << 7) | 32'h73;
  endfunction

  function automatic logic [31:0] m_csrw(input int c, input int rs);
    return (c << 20) | (rs << 15) | (1 << 12) | 32'h73;
  endfunction

  // Reference: list of words the command should produce, or an expected error
  function automatic void model(input logic w, input logic t, input logic p, input int regno);
    logic [31:0] term;
    bit is_csr, is_gpr, postexec_ok;
    exp_q.delete();
    is_csr = (regno <= 'h0FFF);
    is_gpr = (regno >= 'h1000) && (regno <= 'h101F);
`ifdef ABSCMD_POSTEXEC_EN
    postexec_ok = 1;
`else
    postexec_ok = 0;
`endif
    exp_err = (t && !is_csr && !is_gpr) || (p && !postexec_ok);
    term = p ? ((32'h300 << 20) | 32'h67) : 32'h00100073;
    if (exp_err) return;
    if (t && is_gpr) begin
      exp_q.push_back(w ? m_csrr(regno - 'h1000, 'h7B2) : m_csrw('h7B2, regno - 'h1000));
    end else if (t) begin
      exp_q.push_back(m_csrw('h7B3, 1));
      exp_q.push_back(w ? m_csrr(1, 'h7B2) : m_csrr(1, regno));
      exp_q.push_back(w ? m_csrw(regno, 1) : m_csrw('h7B2, 1));
      exp_q.push_back(m_csrr(1, 'h7B3));
    end
    exp_q.push_back(term);
  endfunction

  // mode: 0 ready always, 1 ready toggles starting low, 2 random ready
  // exc_hs: handshake index on which core_exc is raised (-1 none)
  task automatic run_seq(input logic w, input logic t, input logic p, input logic [15:0] regno,
                         input int mode, input int exc_hs, input string tag);
    int idx = 0;
    int cyc = 0;
    logic rdy, exc_now;
    model(w, t, p, int'(regno));
    @(negedge clk);
    cmd_valid = 1; cmd_write = w; cmd_transfer = t; cmd_postexec = p; cmd_regno = regno;
    inst_ready = 0; core_exc = 0;
    total++; if (cmd_ready !== 1'b1) $display("FAIL %s cmd_ready_before: got %b want 1", tag, cmd_ready); else passed++;
    @(negedge clk);
    cmd_valid = 0; cmd_write = 1'($urandom); cmd_transfer = 1'($urandom);
    cmd_postexec = 1'($urandom); cmd_regno = 16'($urandom);
    if (exp_err) begin
      total++; if (err_valid !== 1'b1 || cmderr !== 3'd2) $display("FAIL %s unsup_err: got err_valid=%b cmderr=%0d want 1/2", tag, err_valid, cmderr); else passed++;
      total++; if (inst_valid !== 1'b0 || done !== 1'b0) $display("FAIL %s unsup_quiet: got inst_valid=%b done=%b want 0/0", tag, inst_valid, done); else passed++;
      @(negedge clk);
      total++; if (cmd_ready !== 1'b1 || err_valid !== 1'b0 || cmderr !== 3'd2) $display("FAIL %s unsup_after: got ready=%b err_valid=%b cmderr=%0d want 1/0/2", tag, cmd_ready, err_valid, cmderr); else passed++;
      return;
    end
    while (idx < exp_q.size() && cyc < 200) begin
      total++; if (inst_valid !== 1'b1 || inst !== exp_q[idx]) $display("FAIL %s word%0d: got valid=%b inst=%h want 1/%h", tag, idx, inst_valid, inst, exp_q[idx]); else passed++;
      total++; if (done !== 1'b0 || err_valid !== 1'b0) $display("FAIL %s busy_flags: got done=%b err_valid=%b want 0/0", tag, done, err_valid); else passed++;
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? logic'(cyc % 2) : 1'($urandom_range(0, 1));
      exc_now = rdy && (idx == exc_hs);
      inst_ready = rdy; core_exc = exc_now;
      @(negedge clk);
      cyc++;
      if (exc_now) begin
        core_exc = 0; inst_ready = 0;
        total++; if (inst_valid !== 1'b0 || err_valid !== 1'b1 || cmderr !== 3'd3 || done !== 1'b0) $display("FAIL %s exc: got valid=%b err_valid=%b cmderr=%0d done=%b want 0/1/3/0", tag, inst_valid, err_valid, cmderr, done); else passed++;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1 || err_valid !== 1'b0 || done !== 1'b0 || cmderr !== 3'd3) $display("FAIL %s exc_after: got ready=%b err_valid=%b done=%b cmderr=%0d want 1/0/0/3", tag, cmd_ready, err_valid, done, cmderr); else passed++;
        return;
      end
      if (rdy) idx++;
    end
    inst_ready = 0;
    total++; if (cyc >= 200) $display("FAIL %s timeout: got %0d cycles want <200", tag, cyc); else passed++;
    total++; if (done !== 1'b1 || inst_valid !== 1'b0 || cmd_ready !== 1'b0) $display("FAIL %s done: got done=%b valid=%b ready=%b want 1/0/0", tag, done, inst_valid, cmd_ready); else passed++;
    @(negedge clk);
    total++; if (cmd_ready !== 1'b1 || done !== 1'b0) $display("FAIL %s ready_back: got ready=%b done=%b want 1/0", tag, cmd_ready, done); else passed++;
  endtask

  task automatic test_reset();
    rst_n = 0; cmd_valid = 0; cmd_write = 0; cmd_transfer = 0; cmd_postexec = 0;
    cmd_regno = 0; inst_ready = 0; core_exc = 0;
    repeat (3) @(negedge clk);
    total++; if (inst_valid !== 1'b0 || inst !== 32'd0 || done !== 1'b0 || err_valid !== 1'b0 || cmderr !== 3'd0 || cmd_ready !== 1'b1)
      $display("FAIL reset: got valid=%b inst=%h done=%b err=%b cmderr=%0d ready=%b want 0/0/0/0/0/1", inst_valid, inst, done, err_valid, cmderr, cmd_ready); else passed++;
    rst_n = 1;
    @(negedge clk);
    core_exc = 1;
    @(negedge clk);
    core_exc = 0;
    total++; if (err_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL exc_idle: got err_valid=%b ready=%b want 0/1", err_valid, cmd_ready); else passed++;
  endtask

  task automatic test_gpr_read();
    run_seq(1'b0, 1'b1, 1'b0, 16'h1005, 0, -1, "gpr_read");
  endtask

  task automatic test_csr_write_stall();
    run_seq(1'b1, 1'b1, 1'b0, 16'h0341, 1, -1, "csr_write_stall");
  endtask

  task automatic test_unsupported();
    run_seq(1'b0, 1'b1, 1'b0, 16'h2000, 0, -1, "unsupported");
    run_seq(1'b1, 1'b1, 1'b0, 16'h1020, 0, -1, "unsupported_gpr_edge");
  endtask

  task automatic test_exception();
    run_seq(1'b0, 1'b1, 1'b0, 16'h0300, 0, 2, "exc_csr_read");
    run_seq(1'b1, 1'b1, 1'b0, 16'h101F, 0, 1, "exc_last_hs");
  endtask

  task automatic test_postexec();
    run_seq(1'b0, 1'b0, 1'b1, 16'hFFFF, 0, -1, "postexec");
    run_seq(1'b0, 1'b0, 1'b0, 16'hFFFF, 0, -1, "no_transfer");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cmd_valid = 1; cmd_write = 1; cmd_transfer = 1; cmd_postexec = 0; cmd_regno = 16'h0341;
    @(negedge clk);
    cmd_valid = 0; inst_ready = 1;
    repeat (2) @(negedge clk);
    total++; if (inst !== 32'h34109073) $display("FAIL rst_mid_step2: got %h want 34109073", inst); else passed++;
    rst_n = 0; inst_ready = 0;
    @(negedge clk);
    total++; if (inst_valid !== 1'b0 || inst !== 32'd0 || done !== 1'b0 || err_valid !== 1'b0 || cmderr !== 3'd0 || cmd_ready !== 1'b1)
      $display("FAIL rst_mid: got valid=%b inst=%h done=%b err=%b cmderr=%0d ready=%b want 0/0/0/0/0/1", inst_valid, inst, done, err_valid, cmderr, cmd_ready); else passed++;
    rst_n = 1;
    run_seq(1'b1, 1'b1, 1'b0, 16'h0341, 0, -1, "after_rst_mid");
  endtask

  task automatic test_random();
    logic [15:0] r;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 2))
        0:       r = 16'($urandom_range(0, 'h0FFF));
        1:       r = 16'($urandom_range('h1000, 'h101F));
        default: r = 16'($urandom_range('h1020, 'hFFFF));
      endcase
      run_seq(1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), r, $urandom_range(0, 2),
              ($urandom_range(0, 3) == 0) ? $urandom_range(0, 4) : -1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_gpr_read();
    test_csr_write_stall();
    test_unsupported();
    test_exception();
    test_postexec();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
